cordic_phase_sequencer: RTL and testbench



---
 rtl/cordic_phase_sequencer.sv | 154 +++++++++++++++
 tb/tb_cordic_phase_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_sequencer.sv
// Phase-accumulating angle generator feeding cordic_algorithm; emits Q3.28 angles over valid/ready.
// Build option CORDIC_QUAD_FOLD_EN: fold each angle into [-pi/2, pi/2] and flag the cos/sin negation.
module cordic_phase_sequencer #(
    parameter logic [31:0] TWO_PI        = 32'd1686629713,
    parameter logic [31:0] PI            = 32'd843314857,
    parameter logic [31:0] HALF_PI       = 32'd421657428,
    parameter logic [31:0] THREE_HALF_PI = 32'd1264972285,
    parameter int          CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic        [31:0]      phase_init,
    input  logic        [31:0]      phase_step,
    input  logic        [CNT_W-1:0] num_samples,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [31:0]      angle_out,
    output logic                    negate,
    output logic                    last,
    output logic                    busy,
    output logic                    cfg_err
);

`ifdef CORDIC_QUAD_FOLD_EN
    localparam bit FOLD_EN = 1'b1;
`else
    localparam bit FOLD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                   state_q, state_d;
    logic        [31:0]       phase_q, phase_d;
    logic        [31:0]       step_q, step_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic signed [31:0]       angle_q, angle_d;
    logic                     negate_q, negate_d;
    logic                     last_q, last_d;
    logic                     busy_q, busy_d;
    logic                     cfg_err_q, cfg_err_d;
    logic        [31:0]       nxt_phase;
    logic        [CNT_W-1:0]  cnt_dec;

    // Modulo-2pi accumulate; both operands are below TWO_PI so one subtraction suffices.
    function automatic logic [31:0] wrap(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, TWO_PI})
            sum = sum - {1'b0, TWO_PI};
        return sum[31:0];
    endfunction

    // Returns {negate, angle}.
    function automatic logic [32:0] fold(input logic [31:0] a);
        logic [32:0] r;
        if (!FOLD_EN || a <= HALF_PI)
            r = {1'b0, a};
        else if (a < THREE_HALF_PI)
            r = {1'b1, a - PI};
        else
            r = {1'b0, a - TWO_PI};
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        angle_d   = angle_q;
        negate_d  = negate_q;
        last_d    = last_q;
        busy_d    = busy_q;
        cfg_err_d = 1'b0;
        nxt_phase = wrap(phase_q, step_q);
        cnt_dec   = cnt_q - CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_samples == '0 || phase_init >= TWO_PI || phase_step >= TWO_PI) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        phase_d = phase_init;
                        step_d  = phase_step;
                        cnt_d   = num_samples;
                        busy_d  = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                {negate_d, angle_d} = fold(phase_q);
                last_d  = (cnt_q == CNT_W'(1));
                valid_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (valid_q && out_ready) begin
                    phase_d = nxt_phase;
                    cnt_d   = cnt_dec;
                    if (cnt_q == CNT_W'(1)) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // Next sample loads on the accepting edge to sustain one sample per cycle.
                        {negate_d, angle_d} = fold(nxt_phase);
                        last_d = (cnt_dec == CNT_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            angle_q   <= '0;
            negate_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            angle_q   <= angle_d;
            negate_q  <= negate_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign out_valid = valid_q;
    assign angle_out = angle_q;
    assign negate    = negate_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Self-checking bench for cordic_phase_sequencer: directed vector table, stall/reset/config-error
// sequences and randomized runs against a modulo-arithmetic reference model.
module tb_cordic_phase_sequencer;
    localparam int     CNT_W         = 16;
    localparam longint TWO_PI        = 64'd1686629713;
    localparam longint PI            = 64'd843314857;
    localparam longint HALF_PI       = 64'd421657428;
    localparam longint THREE_HALF_PI = 64'd1264972285;
    localparam longint STEP30        = 64'd140552357;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [31:0]        phase_init;
    logic [31:0]        phase_step;
    logic [CNT_W-1:0]   num_samples;
    logic               out_ready;
    logic               out_valid;
    logic signed [31:0] angle_out;
    logic               negate;
    logic               last;
    logic               busy;
    logic               cfg_err;

    cordic_phase_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .phase_init(phase_init),
        .phase_step(phase_step), .num_samples(num_samples), .out_ready(out_ready),
        .out_valid(out_valid), .angle_out(angle_out), .negate(negate), .last(last),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: k-th phase is (init + k*step) mod 2pi; fold chosen by quadrant.
    function automatic longint ref_phase(input longint init, input longint step, input int k);
        return (init + longint'(k) * step) % TWO_PI;
    endfunction

    task automatic ref_out(input longint ph, output longint ang, output longint neg);
`ifdef CORDIC_QUAD_FOLD_EN
        if (ph <= HALF_PI) begin ang = ph; neg = 0; end
        else if (ph < THREE_HALF_PI) begin ang = ph - PI; neg = 1; end
        else begin ang = ph - TWO_PI; neg = 0; end
`else
        ang = ph; neg = 0;
`endif
    endtask

    typedef struct packed {
        logic [31:0]             init;
        logic [31:0]             step;
        logic [7:0]              n;
        logic [3:0][31:0]        ea;
        logic [3:0]              en;
    } vec_t;

    function automatic vec_t mk(input longint i, input longint s, input int n,
                                input longint a0, input longint a1, input longint a2, input longint a3,
                                input bit n0, input bit n1, input bit n2, input bit n3);
        vec_t v;
        v.init  = i[31:0];
        v.step  = s[31:0];
        v.n     = n[7:0];
        v.ea[0] = a0[31:0]; v.ea[1] = a1[31:0]; v.ea[2] = a2[31:0]; v.ea[3] = a3[31:0];
        v.en    = {n3, n2, n1, n0};
        return v;
    endfunction

    longint q_ang[$];
    bit     q_neg[$];
    bit     q_last[$];
    int     lat, hold_err, stall_cnt;
    bit     busy1, end_busy, end_valid;

    // mode 0: always ready; 1: random ready; 2: ready low 3 cycles after the 2nd handshake
    task automatic run(input longint init, input longint step, input int n, input int mode, input int budget);
        int cyc, stall_left;
        bit done, pv, pr, pn, pl;
        logic [31:0] pa;
        q_ang.delete(); q_neg.delete(); q_last.delete();
        lat = -1; hold_err = 0; stall_cnt = 0; busy1 = 0; end_busy = 1; end_valid = 1;
        @(negedge clk);
        start = 1'b1; phase_init = init[31:0]; phase_step = step[31:0];
        num_samples = n[CNT_W-1:0]; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; done = 0; pv = 0; pr = 1; pa = '0; pn = 0; pl = 0; stall_left = 0;
        while (!done && cyc < budget) begin
            if (cyc == 1) busy1 = busy;
            if (out_valid && lat < 0) lat = cyc;
            if (pv && !pr && out_valid && (angle_out !== pa || negate !== pn || last !== pl))
                hold_err++;
            case (mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = (stall_left == 0);
                default: out_ready = 1'b1;
            endcase
            if (stall_left > 0) stall_left--;
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                q_ang.push_back(longint'(angle_out));
                q_neg.push_back(negate);
                q_last.push_back(last);
                if (last) done = 1;
                if (mode == 2 && q_ang.size() == 2) stall_left = 3;
            end
            pv = out_valid; pr = out_ready; pa = angle_out; pn = negate; pl = last;
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check("run_timeout", 0, 1);
        @(negedge clk);
        end_busy = busy; end_valid = out_valid;
        out_ready = 1'b1;
    endtask

    task automatic verify_model(input string nm, input longint init, input longint step, input int n);
        longint ea, en;
        check({nm, "_count"}, q_ang.size(), n);
        for (int k = 0; k < n && k < q_ang.size(); k++) begin
            ref_out(ref_phase(init, step, k), ea, en);
            check($sformatf("%s_angle%0d", nm, k), q_ang[k], ea);
            check($sformatf("%s_neg%0d", nm, k), q_neg[k], en);
            check($sformatf("%s_last%0d", nm, k), q_last[k], (k == n - 1) ? 1 : 0);
        end
        check({nm, "_hold"}, hold_err, 0);
        check({nm, "_end_busy"}, end_busy, 0);
        check({nm, "_end_valid"}, end_valid, 0);
    endtask

    task automatic cfg_try(input string nm, input longint init, input longint step, input int n);
        @(negedge clk);
        start = 1'b1; phase_init = init[31:0]; phase_step = step[31:0]; num_samples = n[CNT_W-1:0];
        @(negedge clk);
        start = 1'b0;
        check({nm, "_cfg_err"}, cfg_err, 1);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_valid"}, out_valid, 0);
        @(negedge clk);
        check({nm, "_cfg_err_clear"}, cfg_err, 0);
        check({nm, "_valid_after"}, out_valid, 0);
        check({nm, "_busy_after"}, busy, 0);
    endtask

    vec_t tbl[6];

    initial begin
        int waited;
`ifdef CORDIC_QUAD_FOLD_EN
        tbl[0] = mk(0, STEP30, 4, 0, 140552357, 281104714, 421657071, 0, 0, 0, 0);
        tbl[1] = mk(562209429, STEP30, 1, -281105428, 0, 0, 0, 1, 0, 0, 0);
        tbl[2] = mk(1405523573, 421657428, 2, -281106140, 140551288, 0, 0, 0, 0, 0, 0);
        tbl[3] = mk(421657428, 843314857, 3, 421657428, -421657428, -421657428, 0, 0, 0, 1, 0);
        tbl[4] = mk(421657429, 843314855, 2, -421657428, 421657427, 0, 0, 1, 1, 0, 0);
        tbl[5] = mk(1686629712, 1, 2, -1, 0, 0, 0, 0, 0, 0, 0);
`else
        tbl[0] = mk(0, STEP30, 4, 0, 140552357, 281104714, 421657071, 0, 0, 0, 0);
        tbl[1] = mk(562209429, STEP30, 1, 562209429, 0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(1405523573, 421657428, 2, 1405523573, 140551288, 0, 0, 0, 0, 0, 0);
        tbl[3] = mk(421657428, 843314857, 3, 421657428, 1264972285, 421657429, 0, 0, 0, 0, 0);
        tbl[4] = mk(421657429, 843314855, 2, 421657429, 1264972284, 0, 0, 0, 0, 0, 0);
        tbl[5] = mk(1686629712, 1, 2, 1686629712, 0, 0, 0, 0, 0, 0, 0);
`endif
        rst_n = 1'b0; start = 1'b0; phase_init = '0; phase_step = '0;
        num_samples = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_angle", angle_out, 0);
        check("rst_negate", negate, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].init, tbl[i].step, int'(tbl[i].n), 0, 100);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_busy1", i), busy1, 1);
            check($sformatf("vec%0d_count", i), q_ang.size(), int'(tbl[i].n));
            for (int k = 0; k < int'(tbl[i].n) && k < q_ang.size(); k++) begin
                check($sformatf("vec%0d_angle%0d", i, k), q_ang[k], longint'($signed(tbl[i].ea[k])));
                check($sformatf("vec%0d_neg%0d", i, k), q_neg[k], tbl[i].en[k]);
                check($sformatf("vec%0d_last%0d", i, k), q_last[k], (k == int'(tbl[i].n) - 1) ? 1 : 0);
            end
            check($sformatf("vec%0d_end_busy", i), end_busy, 0);
            check($sformatf("vec%0d_end_valid", i), end_valid, 0);
        end

        run(0, STEP30, 6, 2, 100);
        check("stall_cycles", stall_cnt, 3);
        verify_model("stall", 0, STEP30, 6);

        cfg_try("cfg_n0", 0, STEP30, 0);
        cfg_try("cfg_step", 0, TWO_PI, 4);
        cfg_try("cfg_init", TWO_PI, STEP30, 4);

        @(negedge clk);
        start = 1'b1; phase_init = '0; phase_step = STEP30[31:0]; num_samples = 16'd4; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("midrst_valid_seen", out_valid, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_no_cfg_err", cfg_err, 0);
        check("busy_start_still_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_last", last, 0);
        check("midrst_angle", angle_out, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        run(0, STEP30, 4, 0, 100);
        check("rerun_latency", lat, 2);
        verify_model("rerun", 0, STEP30, 4);

        for (int r = 0; r < 20; r++) begin
            longint ri, rs;
            int rn;
            ri = longint'($urandom_range(32'd1686629712, 0));
            rs = longint'($urandom_range(32'd1686629712, 0));
            rn = int'($urandom_range(12, 1));
            run(ri, rs, rn, 1, rn * 40 + 50);
            verify_model($sformatf("rand%0d", r), ri, rs, rn);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
